// File: rtl/w5300_pkg.sv
// rtl/w5300_pkg.sv - W5300 socket register map, TX FSM states and helpers
//  WR/RD           address direction bit, placed above the 9-bit word offset
//  SN_TX_*/SN_CR   socket register word offsets inside one socket block
//  tx_state_e      multi-socket transmitter FSM states
//  tx_words        byte length -> 16-bit word count, odd lengths rounded up
//  get_socket_n_reg  absolute word offset of a register for socket n
package w5300_pkg;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  // Offsets are 16-bit word addresses (byte address >> 1); socket n's block
  // starts at byte 0x200 + n*0x40.
  localparam logic [8:0] SN_REG_BASE   = 9'h100;
  localparam logic [8:0] SN_REG_STRIDE = 9'h020;
  localparam logic [8:0] SN_CR         = 9'h001;
  localparam logic [8:0] SN_TX_WRSR0   = 9'h010;
  localparam logic [8:0] SN_TX_WRSR2   = 9'h011;
  localparam logic [8:0] SN_TX_FSR0    = 9'h012;
  localparam logic [8:0] SN_TX_FSR2    = 9'h013;
  localparam logic [8:0] SN_TX_FIFOR   = 9'h017;

  localparam logic [15:0] SN_CR_SEND = 16'h0020;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_HDR0,
    ST_HDR1,
    ST_FSR0,
    ST_FSR2,
    ST_CHECK,
    ST_FIFO,
    ST_WRSR0,
    ST_WRSR2,
    ST_CMD,
    ST_DONE,
    ST_ERR
  } tx_state_e;

  function automatic logic [31:0] tx_words(input logic [31:0] len);
    return (len + 32'd1) >> 1;
  endfunction

  function automatic logic [8:0] get_socket_n_reg(input logic [8:0] reg_off,
                                                  input logic [2:0] sock);
    return SN_REG_BASE + SN_REG_STRIDE * {6'd0, sock} + reg_off;
  endfunction

endpackage

// File: rtl/w5300_rr_arbiter.sv
// rtl/w5300_rr_arbiter.sv - round-robin arbiter with a last-winner pointer
//  clk, rst_n   clock, asynchronous active-low reset
//  req_i[N]     request levels
//  adv_i        accept the current grant: the pointer moves to the winner
//  gnt_o[N]     one-hot grant (all zero when nothing is requested)
//  idx_o        index of the granted requester
module w5300_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o,
  output logic [2:0]   idx_o
);

  logic [2:0] last_q;
  logic [3:0] cand;
  logic       found;

  // Walk candidates last+1, last+2, ... wrapping at N; the first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last_q} + 4'(i);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      for (int j = 0; j < N; j++) begin
        if (!found && cand == 4'(j) && req_i[j]) begin
          found    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = 3'(j);
        end
      end
    end
  end

  // Reset points at the last requester so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 3'(N - 1);
    end else if (adv_i && found) begin
      last_q <= idx_o;
    end
  end

endmodule

// File: rtl/w5300_multi_transmitter.sv
// rtl/w5300_multi_transmitter.sv - round-robin multi-socket W5300 TX engine
//  clk, rst_n         clock, asynchronous active-low reset
//  tx_req[NUM_SOCK]   per-socket request level, held until tx_done/tx_err
//  tx_done, tx_err    one-cycle per-socket completion / drop pulses
//  tx_sock            socket being served (selects the local buffer)
//  busy               high whenever the FSM is not idle
//  buf_addr, buf_data local TX buffer word address and read data
//  addr, wr_data      {dir, word offset} and write data of the current access
//  rd_data, op_state  read data and one-cycle access-complete pulse
module w5300_multi_transmitter
  import w5300_pkg::*;
#(
  parameter int         NUM_SOCK   = 4,
  parameter logic [2:0] SOCK_BASE  = 3'd0,
  parameter int         BUF_AW     = 16,
  parameter int         POLL_LIMIT = 255,
  parameter int         MAX_LEN    = 1472
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SOCK-1:0] tx_req,
  output logic [NUM_SOCK-1:0] tx_done,
  output logic [NUM_SOCK-1:0] tx_err,
  output logic [2:0]          tx_sock,
  output logic                busy,
  output logic [BUF_AW-1:0]   buf_addr,
  input  logic [15:0]         buf_data,
  output logic [9:0]          addr,
  output logic [15:0]         wr_data,
  input  logic [15:0]         rd_data,
  input  logic                op_state
);

  tx_state_e           state_q, state_d;
  logic [2:0]          tx_sock_q, tx_sock_d;
  logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
  logic [31:0]         len_q, len_d;
  logic [31:0]         fsr_q, fsr_d;
  logic [15:0]         poll_cnt_q, poll_cnt_d;
  logic [31:0]         word_cnt_q, word_cnt_d;

  logic                arb_adv;
  logic [NUM_SOCK-1:0] arb_gnt;
  logic [2:0]          arb_idx;
  logic [2:0]          sock_n;
  logic [31:0]         len_hdr;

  w5300_rr_arbiter #(.N(NUM_SOCK)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (tx_req),
    .adv_i (arb_adv),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    tx_sock_d  = tx_sock_q;
    buf_addr_d = buf_addr_q;
    len_d      = len_q;
    fsr_d      = fsr_q;
    poll_cnt_d = poll_cnt_q;
    word_cnt_d = word_cnt_q;
    arb_adv    = 1'b0;
    addr       = {RD, 9'h000};
    wr_data    = '0;
    tx_done    = '0;
    tx_err     = '0;
    sock_n     = SOCK_BASE + tx_sock_q;
    // Full length as it becomes known in Hdr1, before len_q is updated.
    len_hdr    = {len_q[31:16], buf_data};

    case (state_q)
      ST_IDLE: begin
        if (|tx_req) state_d = ST_ARB;
      end
      ST_ARB: begin
        buf_addr_d = '0;
        if (|arb_gnt) begin
          arb_adv   = 1'b1;
          tx_sock_d = arb_idx;
          state_d   = ST_HDR0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR0: begin
        len_d[31:16] = buf_data;
        buf_addr_d   = buf_addr_q + BUF_AW'(1);
        state_d      = ST_HDR1;
      end
      ST_HDR1: begin
        len_d[15:0] = buf_data;
        buf_addr_d  = buf_addr_q + BUF_AW'(1);
        if (len_hdr == 32'd0)               state_d = ST_DONE;
        else if (len_hdr > 32'(MAX_LEN))    state_d = ST_ERR;
        else                                state_d = ST_FSR0;
      end
      ST_FSR0: begin
        addr = {RD, get_socket_n_reg(SN_TX_FSR0, sock_n)};
        if (op_state) begin
          fsr_d[31:16] = rd_data;
          state_d      = ST_FSR2;
        end
      end
      ST_FSR2: begin
        addr = {RD, get_socket_n_reg(SN_TX_FSR2, sock_n)};
        if (op_state) begin
          fsr_d[15:0] = rd_data;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (fsr_q >= len_q) begin
          state_d = ST_FIFO;
        end else if (poll_cnt_q + 16'd1 == 16'(POLL_LIMIT)) begin
          state_d = ST_ERR;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
          state_d    = ST_FSR0;
        end
      end
      ST_FIFO: begin
        addr    = {WR, get_socket_n_reg(SN_TX_FIFOR, sock_n)};
        wr_data = buf_data;
        if (op_state) begin
          buf_addr_d = buf_addr_q + BUF_AW'(1);
          word_cnt_d = word_cnt_q + 32'd1;
          if (word_cnt_d == tx_words(len_q)) state_d = ST_WRSR0;
        end
      end
      ST_WRSR0: begin
        addr    = {WR, get_socket_n_reg(SN_TX_WRSR0, sock_n)};
        wr_data = len_q[31:16];
        if (op_state) state_d = ST_WRSR2;
      end
      ST_WRSR2: begin
        addr    = {WR, get_socket_n_reg(SN_TX_WRSR2, sock_n)};
        wr_data = len_q[15:0];
        if (op_state) state_d = ST_CMD;
      end
      ST_CMD: begin
        addr    = {WR, get_socket_n_reg(SN_CR, sock_n)};
        wr_data = SN_CR_SEND;
        if (op_state) state_d = ST_DONE;
      end
      ST_DONE: begin
        for (int i = 0; i < NUM_SOCK; i++) tx_done[i] = (tx_sock_q == 3'(i));
        poll_cnt_d = '0;
        word_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        for (int i = 0; i < NUM_SOCK; i++) tx_err[i] = (tx_sock_q == 3'(i));
        poll_cnt_d = '0;
        word_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_sock_q  <= '0;
      buf_addr_q <= '0;
      len_q      <= '0;
      fsr_q      <= '0;
      poll_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_sock_q  <= tx_sock_d;
      buf_addr_q <= buf_addr_d;
      len_q      <= len_d;
      fsr_q      <= fsr_d;
      poll_cnt_q <= poll_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign tx_sock  = tx_sock_q;
  assign buf_addr = buf_addr_q;

endmodule

// File: tb/tb_w5300_multi_transmitter.sv
// tb/tb_w5300_multi_transmitter.sv - scoreboard bench for w5300_multi_transmitter
module tb_w5300_multi_transmitter;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] tx_req;
  logic [NS-1:0] tx_done, tx_err;
  logic [2:0]    tx_sock;
  logic          busy;
  logic [15:0]   buf_addr;
  logic [15:0]   buf_data;
  logic [9:0]    addr;
  logic [15:0]   wr_data;
  logic [15:0]   rd_data;
  logic          op_state;

  logic [15:0]   mem [0:63];
  logic [31:0]   fsr_val;
  logic [25:0]   exp_bus_q[$];
  logic [25:0]   obs_bus_q[$];
  logic [7:0]    exp_evt_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  bit            lat = 1'b0;

  // W5300 socket register byte offsets
  localparam logic [9:0] B_CR    = 10'h002;
  localparam logic [9:0] B_WRSR0 = 10'h020;
  localparam logic [9:0] B_WRSR2 = 10'h022;
  localparam logic [9:0] B_FSR0  = 10'h024;
  localparam logic [9:0] B_FSR2  = 10'h026;
  localparam logic [9:0] B_FIFOR = 10'h02E;

  always #5 clk = ~clk;

  assign buf_data = mem[buf_addr[5:0]];

  w5300_multi_transmitter #(
    .NUM_SOCK(NS), .SOCK_BASE(3'd0), .BUF_AW(16), .POLL_LIMIT(3), .MAX_LEN(1472)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_done(tx_done), .tx_err(tx_err),
    .tx_sock(tx_sock), .busy(busy), .buf_addr(buf_addr), .buf_data(buf_data),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .op_state(op_state)
  );

  // Bus controller: each access completes on its second cycle.
  always @(negedge clk) begin
    if (rst_n && addr != 10'h000) begin
      if (lat) begin
        op_state = 1'b1;
        rd_data  = addr[9] ? 16'h0000 : (addr[0] ? fsr_val[15:0] : fsr_val[31:16]);
        obs_bus_q.push_back({addr, wr_data});
        lat = 1'b0;
      end else begin
        op_state = 1'b0;
        lat = 1'b1;
      end
    end else begin
      op_state = 1'b0;
      lat = 1'b0;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] exp_addr(bit wr, int s, logic [9:0] off);
    logic [9:0] b;
    b = 10'h200 + 10'(s * 64) + off;
    return {wr, b[9:1]};
  endfunction

  task automatic push_bus(bit wr, int s, logic [9:0] off, logic [15:0] d);
    exp_bus_q.push_back({exp_addr(wr, s, off), d});
  endtask

  task automatic push_poll(int s);
    push_bus(1'b0, s, B_FSR0, 16'h0000);
    push_bus(1'b0, s, B_FSR2, 16'h0000);
  endtask

  task automatic load(int len);
    logic [31:0] l;
    l = 32'(len);
    mem[0] = l[31:16];
    mem[1] = l[15:0];
    for (int i = 2; i < 64; i++) mem[i] = 16'($urandom);
  endtask

  task automatic push_frame(int s, int len);
    logic [31:0] l;
    l = 32'(len);
    push_poll(s);
    for (int i = 0; i < (len + 1) / 2; i++) push_bus(1'b1, s, B_FIFOR, mem[2 + i]);
    push_bus(1'b1, s, B_WRSR0, l[31:16]);
    push_bus(1'b1, s, B_WRSR2, l[15:0]);
    push_bus(1'b1, s, B_CR, 16'h0020);
  endtask

  task automatic drain();
    logic [25:0] o, e;
    while (obs_bus_q.size() != 0) begin
      o = obs_bus_q.pop_front();
      chk("bus_expected", 32'(exp_bus_q.size() != 0), 32'd1);
      if (exp_bus_q.size() != 0) begin
        e = exp_bus_q.pop_front();
        chk("bus_access", 32'(o), 32'(e));
      end
    end
  endtask

  task automatic run(int n_evt, bit hold, int budget);
    int got = 0;
    logic [7:0] e;
    for (int c = 0; c < budget && got < n_evt; c++) begin
      @(negedge clk);
      drain();
      if ((tx_done | tx_err) != '0) begin
        chk("evt_expected", 32'(exp_evt_q.size() != 0), 32'd1);
        if (exp_evt_q.size() != 0) begin
          e = exp_evt_q.pop_front();
          chk("evt_pulse", 32'({tx_err, tx_done}), 32'(e));
        end
        got++;
        if (!hold) tx_req = tx_req & ~(tx_done | tx_err);
      end
    end
    chk("evt_count", 32'(got), 32'(n_evt));
    tx_req = '0;
    @(negedge clk);
    drain();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(tx_done), 32'd0);
    chk({tag, "_err"}, 32'(tx_err), 32'd0);
    chk({tag, "_sock"}, 32'(tx_sock), 32'd0);
    chk({tag, "_buf_addr"}, 32'(buf_addr), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    logic [NS-1:0] seen;
    int c;
    rst_n = 1'b0; tx_req = '0; op_state = 1'b0; rd_data = '0; fsr_val = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: socket 0, 6 bytes
    fsr_val = 32'h0000_1000;
    load(6); push_frame(0, 6); exp_evt_q.push_back(8'b0000_0001);
    tx_req = 4'b0001;
    run(1, 1'b0, 200);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: socket 3, odd length rounds up to 3 words
    load(5); push_frame(3, 5); exp_evt_q.push_back(8'b0000_1000);
    tx_req = 4'b1000;
    run(1, 1'b0, 200);

    // 3: held requests served 0,1,3,0
    load(4);
    push_frame(0, 4); exp_evt_q.push_back(8'b0000_0001);
    push_frame(1, 4); exp_evt_q.push_back(8'b0000_0010);
    push_frame(3, 4); exp_evt_q.push_back(8'b0000_1000);
    push_frame(0, 4); exp_evt_q.push_back(8'b0000_0001);
    tx_req = 4'b1011;
    run(4, 1'b1, 600);

    // 4: free size never sufficient -> three polls then error
    fsr_val = 32'h0000_0002;
    load(100);
    push_poll(2); push_poll(2); push_poll(2);
    exp_evt_q.push_back(8'b0100_0000);
    tx_req = 4'b0100;
    run(1, 1'b0, 200);

    // 5: zero length completes silently; oversize length is dropped
    fsr_val = 32'h0000_1000;
    load(0); exp_evt_q.push_back(8'b0000_0010);
    tx_req = 4'b0010;
    run(1, 1'b0, 50);
    load(2000); exp_evt_q.push_back(8'b0010_0000);
    tx_req = 4'b0010;
    run(1, 1'b0, 50);

    // 6: reset during the payload, no SEND afterwards
    load(20);
    push_poll(1);
    for (int i = 0; i < 3; i++) push_bus(1'b1, 1, B_FIFOR, mem[2 + i]);
    tx_req = 4'b0010;
    c = 0;
    while (exp_bus_q.size() != 0 && c < 200) begin
      @(negedge clk);
      drain();
      c++;
    end
    chk("t6_reached_fifo", 32'(exp_bus_q.size()), 32'd0);
    rst_n = 1'b0;
    tx_req = '0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      drain();
      seen = seen | tx_done | tx_err;
    end
    chk("t6_no_evt", 32'(seen), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    chk("bus_leftover", 32'(exp_bus_q.size()), 32'd0);
    chk("evt_leftover", 32'(exp_evt_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
